// File: rtl/axis_vip_playback_pkg.sv
// axis_vip_playback_pkg: shared defaults and FSM state type for the AXIS playback source.
package axis_vip_playback_pkg;
    localparam int DEF_FFT_LEN      = 4096;
    localparam int DEF_SAMP_PER_CLK = 2;
    localparam int DEF_ADC_BITS     = 12;
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} vip_pb_state_t;
endpackage

// File: rtl/axis_vip_playback_ram.sv
// vip_playback_ram: simple dual-port sample RAM with a registered 1-cycle-latency read port.
module vip_playback_ram #(
    parameter int DW    = 24,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/axis_vip_playback.sv
// axis_vip_playback: streams a preloaded sample RAM as framed AXIS beats, one-shot or looped.
module axis_vip_playback
    import axis_vip_playback_pkg::*;
#(
    parameter int SAMP_PER_CLK = DEF_SAMP_PER_CLK,
    parameter int ADC_BITS     = DEF_ADC_BITS,
    parameter int DEPTH        = 4096,
    parameter int FRAME_BEATS  = DEF_FFT_LEN / DEF_SAMP_PER_CLK,
    parameter int LOOP         = 0,
    localparam int DW = SAMP_PER_CLK * ADC_BITS,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          m_axis_tuser,
    output logic          busy,
    output logic          done,
    output logic [31:0]   frames_sent
);
    localparam int BW = FRAME_BEATS > 1 ? $clog2(FRAME_BEATS) : 1;
    vip_pb_state_t state;
    logic [AW-1:0] rd_addr, out_addr;
    logic [BW-1:0] beat;
    logic [DW-1:0] ram_q, fwd_data, din;
    logic [DW-1:0] q [3];
    logic [DW-1:0] q_n [3];
    logic [1:0] cnt, cnt_n;
    logic rd_vld, rd_end, first, stop_req, fwd;
    logic run, hs, push, rd_en, ram_we, last_beat, end_beat, end_run, stop_run, leave;
    vip_playback_ram #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_ram (
        .clk(clk), .wr_en(ram_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(ram_q)
    );
    always_comb begin
        run = state == PRIME || state == STREAM;
        busy = state != IDLE;
        m_axis_tvalid = state == STREAM && cnt != 2'd0;
        hs = m_axis_tvalid && m_axis_tready;
        last_beat = beat == BW'(FRAME_BEATS - 1);
        end_beat = out_addr == AW'(DEPTH - 1);
        m_axis_tlast = m_axis_tvalid && last_beat;
        m_axis_tuser = m_axis_tvalid && first;
        m_axis_tdata = q[0];
        end_run = hs && end_beat && LOOP == 0;
        stop_run = hs && last_beat && (stop_req || !en);
        leave = state == STREAM && (end_run || stop_run);
        ram_we = wr_en && state == IDLE;
        // prefetch only while the output register plus both skid slots can absorb the reply
        rd_en = (state == IDLE && en) || (run && !rd_end && ({1'b0, cnt} + {2'b0, rd_vld} < 3'd3));
        push = run && rd_vld;
        // a write landing on address 0 in the start cycle must be seen by the first read
        din = fwd ? fwd_data : ram_q;
        cnt_n = cnt + {1'b0, push} - {1'b0, hs};
        q_n[0] = hs ? q[1] : q[0];
        q_n[1] = hs ? q[2] : q[1];
        q_n[2] = q[2];
        if (push) q_n[cnt - {1'b0, hs}] = din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_addr     <= '0;
            out_addr    <= '0;
            beat        <= '0;
            rd_vld      <= 1'b0;
            rd_end      <= 1'b0;
            first       <= 1'b0;
            stop_req    <= 1'b0;
            fwd         <= 1'b0;
            fwd_data    <= '0;
            cnt         <= '0;
            q           <= '{default: '0};
            wr_err      <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            wr_err   <= wr_en && state != IDLE;
            rd_vld   <= rd_en;
            fwd      <= ram_we && rd_en && wr_addr == rd_addr;
            fwd_data <= wr_data;
            cnt      <= cnt_n;
            q        <= q_n;
            if (rd_en) rd_addr <= rd_addr == AW'(DEPTH - 1) ? '0 : rd_addr + 1'b1;
            if (rd_en && rd_addr == AW'(DEPTH - 1) && LOOP == 0) rd_end <= 1'b1;
            if (run && !en) stop_req <= 1'b1;
            if (hs) begin
                out_addr <= end_beat ? '0 : out_addr + 1'b1;
                beat     <= last_beat ? '0 : beat + 1'b1;
                first    <= 1'b0;
                if (last_beat) frames_sent <= frames_sent + 32'd1;
            end
            unique case (state)
                IDLE: if (en) begin
                    state <= PRIME;
                    first <= 1'b1;
                end
                PRIME: state <= STREAM;
                STREAM: if (end_run) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else if (stop_run) state <= IDLE;
                DONE: if (!en) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // prefetched beats are dropped and the read side rewinds for the next run
            if (leave) begin
                rd_addr  <= '0;
                rd_end   <= 1'b0;
                cnt      <= '0;
                out_addr <= '0;
                beat     <= '0;
                stop_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_vip_playback.sv
// tb_axis_vip_playback: directed self-checking bench driving a one-shot and a looped instance in parallel.
module tb_axis_vip_playback;
    localparam int DEPTH = 64;
    localparam int FB    = 16;
    localparam int DW    = 24;
    localparam int AW    = 6;
    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        logic        last;
        logic        user;
    } spot_t;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, wr_en = 1'b0, tready = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic os_wr_err, os_tvalid, os_tlast, os_tuser, os_busy, os_done;
    logic lp_wr_err, lp_tvalid, lp_tlast, lp_tuser, lp_busy, lp_done;
    logic [DW-1:0] os_tdata, lp_tdata;
    logic [31:0] os_frames, lp_frames;
    int checks = 0, errors = 0, cyc = 0;
    logic sel = 1'b0, mon_on = 1'b0, stalled = 1'b0;
    logic [DW-1:0] st_data;
    logic st_last, st_user;
    logic [DW-1:0] got_data [$];
    logic got_last [$];
    logic got_user [$];
    int got_cyc [$];
    spot_t spots [8];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    axis_vip_playback #(.DEPTH(DEPTH), .FRAME_BEATS(FB), .LOOP(0)) u_os (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(os_wr_err), .m_axis_tdata(os_tdata), .m_axis_tvalid(os_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(os_tlast), .m_axis_tuser(os_tuser),
        .busy(os_busy), .done(os_done), .frames_sent(os_frames)
    );
    axis_vip_playback #(.DEPTH(DEPTH), .FRAME_BEATS(FB), .LOOP(1)) u_lp (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(lp_wr_err), .m_axis_tdata(lp_tdata), .m_axis_tvalid(lp_tvalid),
        .m_axis_tready(tready), .m_axis_tlast(lp_tlast), .m_axis_tuser(lp_tuser),
        .busy(lp_busy), .done(lp_done), .frames_sent(lp_frames)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_mon(input logic s);
        sel = s;
        got_data.delete();
        got_last.delete();
        got_user.delete();
        got_cyc.delete();
        stalled = 1'b0;
        mon_on = 1'b1;
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((os_busy || lp_busy) && n < 200) begin
            tick();
            n++;
        end
        chk("idle", {30'd0, os_busy, lp_busy}, 32'd0);
    endtask
    task automatic wait_done(input int max);
        int n = 0;
        while (!os_done && n < max) begin
            tick();
            n++;
        end
        chk("done", os_done, 1);
    endtask
    task automatic check_run(input string tag, input int n, input logic gapless);
        int bad = 0;
        chk({tag, "_beats"}, got_data.size(), n);
        for (int i = 0; i < got_data.size() && i < n; i++)
            if (got_data[i] !== DW'(i % DEPTH) || got_last[i] !== (i % FB == FB - 1) || got_user[i] !== (i == 0))
                bad++;
        chk({tag, "_seq_bad_beats"}, bad, 0);
        if (gapless && got_cyc.size() > 0)
            chk({tag, "_gapless_span"}, got_cyc[got_cyc.size()-1] - got_cyc[0], got_cyc.size() - 1);
    endtask
    always @(negedge clk) begin : mon
        logic v, l, u;
        logic [DW-1:0] d;
        v = sel ? lp_tvalid : os_tvalid;
        d = sel ? lp_tdata : os_tdata;
        l = sel ? lp_tlast : os_tlast;
        u = sel ? lp_tuser : os_tuser;
        if (mon_on) begin
            if (stalled) begin
                chk("hold_valid", v, 1);
                chk("hold_data", d, st_data);
                chk("hold_last", l, st_last);
                chk("hold_user", u, st_user);
            end
            if (v && tready) begin
                got_data.push_back(d);
                got_last.push_back(l);
                got_user.push_back(u);
                got_cyc.push_back(cyc);
            end
            stalled = v && !tready;
            st_data = d;
            st_last = l;
            st_user = u;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        spots[0] = '{0,  24'd0,  1'b0, 1'b1};
        spots[1] = '{1,  24'd1,  1'b0, 1'b0};
        spots[2] = '{14, 24'd14, 1'b0, 1'b0};
        spots[3] = '{15, 24'd15, 1'b1, 1'b0};
        spots[4] = '{16, 24'd16, 1'b0, 1'b0};
        spots[5] = '{31, 24'd31, 1'b1, 1'b0};
        spots[6] = '{47, 24'd47, 1'b1, 1'b0};
        spots[7] = '{63, 24'd63, 1'b1, 1'b0};
        tick();
        tick();
        chk("rst_tvalid", os_tvalid, 0);
        chk("rst_tlast", os_tlast, 0);
        chk("rst_tuser", os_tuser, 0);
        chk("rst_tdata", os_tdata, 0);
        chk("rst_busy", os_busy, 0);
        chk("rst_done", os_done, 0);
        chk("rst_frames", os_frames, 0);
        chk("rst_wr_err", os_wr_err, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_addr = AW'(i);
            wr_data = (i == 0) ? 24'hABC : DW'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("wr_err_idle", os_wr_err, 0);
        // one-shot run; address 0 is rewritten in the start cycle and must be played as 0
        tready = 1'b1;
        clear_mon(1'b0);
        en = 1'b1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        tick();
        wr_en = 1'b0;
        chk("wr_err_start_cycle", os_wr_err, 0);
        chk("prime_busy", os_busy, 1);
        chk("prime_tvalid", os_tvalid, 0);
        tick();
        chk("first_tvalid", os_tvalid, 1);
        chk("first_tuser", os_tuser, 1);
        chk("first_tdata", os_tdata, 0);
        wait_done(200);
        mon_on = 1'b0;
        chk("os_tvalid_done", os_tvalid, 0);
        chk("os_frames_run1", os_frames, 4);
        check_run("run1", 64, 1'b1);
        foreach (spots[k])
            if (spots[k].idx < got_data.size()) begin
                chk("spot_data", got_data[spots[k].idx], spots[k].data);
                chk("spot_last", got_last[spots[k].idx], spots[k].last);
                chk("spot_user", got_user[spots[k].idx], spots[k].user);
            end
        en = 1'b0;
        tick();
        chk("done_clear", os_done, 0);
        chk("os_idle_after_done", os_busy, 0);
        wait_idle();
        // random backpressure
        clear_mon(1'b0);
        en = 1'b1;
        for (int n = 0; n < 1000 && !os_done; n++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rand_done", os_done, 1);
        mon_on = 1'b0;
        check_run("rand", 64, 1'b0);
        chk("os_frames_run2", os_frames, 8);
        tready = 1'b1;
        en = 1'b0;
        tick();
        wait_idle();
        // write while streaming is dropped
        clear_mon(1'b0);
        en = 1'b1;
        repeat (6) tick();
        wr_en = 1'b1;
        wr_addr = 6'd40;
        wr_data = 24'hFFF;
        tick();
        wr_en = 1'b0;
        chk("wr_err_pulse", os_wr_err, 1);
        chk("lp_wr_err_pulse", lp_wr_err, 1);
        tick();
        chk("wr_err_clear", os_wr_err, 0);
        wait_done(200);
        mon_on = 1'b0;
        check_run("wrdrop", 64, 1'b1);
        chk("os_frames_run3", os_frames, 12);
        en = 1'b0;
        tick();
        wait_idle();
        // reset mid-run, then replay from the preserved RAM
        clear_mon(1'b0);
        en = 1'b1;
        for (int n = 0; n < 100 && got_data.size() < 20; n++) tick();
        chk("reach_beat20", got_data.size(), 20);
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", os_tvalid, 0);
        chk("midrst_tlast", os_tlast, 0);
        chk("midrst_tuser", os_tuser, 0);
        chk("midrst_tdata", os_tdata, 0);
        chk("midrst_busy", os_busy, 0);
        chk("midrst_frames", os_frames, 0);
        chk("midrst_lp_tvalid", lp_tvalid, 0);
        chk("midrst_lp_busy", lp_busy, 0);
        tick();
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        clear_mon(1'b0);
        en = 1'b1;
        wait_done(200);
        mon_on = 1'b0;
        check_run("replay", 64, 1'b1);
        chk("os_frames_replay", os_frames, 4);
        en = 1'b0;
        tick();
        wait_idle();
        // looped instance: drop en at beat 150, expect stop after beat 159
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clear_mon(1'b1);
        en = 1'b1;
        for (int n = 0; n < 400 && got_data.size() < 150; n++) tick();
        chk("reach_beat150", got_data.size(), 150);
        en = 1'b0;
        for (int n = 0; n < 100 && lp_busy; n++) tick();
        chk("lp_idle", lp_busy, 0);
        mon_on = 1'b0;
        check_run("loop", 160, 1'b1);
        chk("lp_frames", lp_frames, 10);
        chk("lp_tvalid_off", lp_tvalid, 0);
        chk("lp_done", lp_done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_vip_playback.md
# axis_vip_playback

AXI-Stream playback source: the transmit-side counterpart of the capture VIP that fills a RAM and raises `full`. A host or testbench preloads a sample RAM through a simple write port. On `en` the block streams the RAM contents out as framed AXIS beats with full `tready` backpressure, one-shot or looped. It is used to drive the OSPFB input (`s_axis_ospfb`) with deterministic vectors in place of the ADC model.

## Interface
Parameters:
- `SAMP_PER_CLK`, 2: samples per beat.
- `ADC_BITS`, 12: bits per sample; `tdata` is `SAMP_PER_CLK*ADC_BITS` wide.
- `DEPTH`, 4096: RAM depth in beats; must be a multiple of `FRAME_BEATS`.
- `FRAME_BEATS`, `FFT_LEN/SAMP_PER_CLK`: beats per frame.
- `LOOP`, 0: 1 = wrap to address 0 after the last beat; 0 = one-shot.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start (level); deassertion stops playback at a frame boundary.
- `wr_en`  in  1  RAM write strobe.
- `wr_addr`  in  `$clog2(DEPTH)`  RAM write address.
- `wr_data`  in  `SAMP_PER_CLK*ADC_BITS`  RAM write data.
- `wr_err`  out  1  one-cycle pulse: write attempted while not IDLE (write dropped).
- `m_axis_tdata`  out  `SAMP_PER_CLK*ADC_BITS`  sample beat.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of each frame.
- `m_axis_tuser`  out  1  first beat of a playback run.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-shot run complete; held until `en` goes low.
- `frames_sent`  out  32  count of accepted `tlast` beats; wraps at 2^32; cleared only by `rst`.

## Operation
- Reset: state IDLE. All outputs 0. Read address 0, beat-in-frame counter 0.
- IDLE: writes are accepted. When `en`=1, go to PRIME and issue a read of address 0.
- PRIME: one cycle to cover the RAM read latency; then go to STREAM.
- STREAM: present beats from an output register plus a 2-entry skid buffer, so a read is always issued one cycle ahead.
  - The read address advances only when a skid slot will be free.
  - A beat transfers when `tvalid & tready`.
  - `tlast`=1 when beat-in-frame = `FRAME_BEATS-1`.
  - `tuser`=1 on the first beat after PRIME only.
- End of data (accepted beat at address `DEPTH-1`):
  - `LOOP`=0: go to DONE.
  - `LOOP`=1: address wraps to 0 and streaming continues without a bubble. `tuser` is not reasserted on wrap.
- `en` low during STREAM: finish the current frame. After the accepted `tlast` beat, go to IDLE with no further `tvalid`. Prefetched data is discarded.
- DONE: `tvalid`=0, `done`=1. When `en`=0, go to IDLE and `done`=0.
- `en` low during PRIME: complete PRIME, emit exactly one frame, then go to IDLE.
- Writes while not IDLE: dropped, `wr_err` pulses. A write and `en` in the same IDLE cycle: the write completes and is included in the run.
- `rst` asserted mid-run: immediately returns to IDLE with outputs 0. RAM contents are preserved; no re-initialization is required.

## Timing
- `en` sampled high at edge N (IDLE) → PRIME at N+1 → `tvalid`=1 after edge N+2.
- With `tready` held high: one beat per cycle, no bubbles, including across frame and loop boundaries.
- AXIS rule: once `tvalid`=1, `tdata`/`tlast`/`tuser` stay stable until the handshake. `tvalid` never drops without a handshake, except on `rst`.
- `tready` may toggle every cycle. Throughput recovers to 1 beat/cycle on the cycle after `tready` returns high.
- `frames_sent` updates on the edge after the accepted `tlast` beat.
- `done` rises on the edge after the final accepted beat.

## Structure
- Add `vip_pb_state_t` (IDLE, PRIME, STREAM, DONE) to `alpaca_dtypes_pkg`.
- Defaults for `SAMP_PER_CLK`, `ADC_BITS`, `FFT_LEN` come from `alpaca_constants_pkg`.
- Sub-module `vip_playback_ram`: simple dual-port RAM (write port, registered read port, 1-cycle latency) so it infers BRAM.
- The FSM, counters and skid buffer stay in the top.

## Test plan
- Load `DEPTH`=64, `FRAME_BEATS`=16 with data[i]=i; `LOOP`=0, `tready`=1, pulse `en` → 64 beats of 0..63 with no gaps; `tlast` on beats 15/31/47/63; `tuser` on beat 0 only; `frames_sent`=4; `done`=1.
- Same vectors with random `tready` (50%) → identical 0..63 sequence with no drops or duplicates; `tdata` stable while `tvalid & ~tready`.
- `LOOP`=1, `en` held for 150 beats then dropped at beat 150 → sequence wraps 63→0 with no bubble; stops after beat 159 (`tlast`); `frames_sent`=10; IDLE.
- Write during STREAM → `wr_err` pulses 1 cycle; replaying afterwards shows unchanged RAM contents.
- `rst` asserted at beat 20, released, `en` pulsed again → all outputs 0 during reset; new run starts at data 0 with `tuser`=1.
- Latency check: `en` rises at cycle N → first `tvalid` at N+2.
